// File: rtl/order_no_ascii_counter.sv
// order_no_ascii_counter
//
// N-digit decimal (BCD) order-number counter. The count is presented as
// ASCII, one byte per digit, for display and logging. Supports a variable
// step of 0..9, a BCD parallel load, a synchronous clear, and wrap or
// saturate behaviour at the top of range.
//
// Parameters:
//   NUM_DIGITS  number of decimal digits (1..8)
//   SAT_MODE    0 = wrap to all zeros, 1 = saturate at all nines
//
// Ports:
//   clk         system clock, rising edge
//   rst_n       synchronous active-low reset
//   clear       synchronous clear of the count to zero
//   load        parallel load strobe
//   load_bcd    BCD load value, digit 0 in [3:0]
//   enable      add step to the count this cycle
//   step        increment amount (0..9 legal)
//   order_no    ASCII digits, byte k = digit k
//   wrap        pulse: increment wrapped past all nines (SAT_MODE=0)
//   sat         pulse: increment clipped at all nines (SAT_MODE=1)
//   ovf_sticky  set on wrap/sat; cleared by reset, clear or accepted load
//   load_err    pulse: load rejected, a nibble was above 9
//   step_err    pulse: enable with step above 9, increment suppressed
module order_no_ascii_counter #(
    parameter int NUM_DIGITS = 5,
    parameter bit SAT_MODE   = 1'b0
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    clear,
    input  logic                    load,
    input  logic [4*NUM_DIGITS-1:0] load_bcd,
    input  logic                    enable,
    input  logic [3:0]              step,
    output logic [8*NUM_DIGITS-1:0] order_no,
    output logic                    wrap,
    output logic                    sat,
    output logic                    ovf_sticky,
    output logic                    load_err,
    output logic                    step_err
);

    localparam int BCD_W   = 4 * NUM_DIGITS;
    localparam int ASCII_W = 8 * NUM_DIGITS;

    logic [BCD_W-1:0]      count_reg;
    logic [BCD_W-1:0]      count_next;
    logic [ASCII_W-1:0]    order_no_reg;
    logic [ASCII_W-1:0]    order_no_next;
    logic                  wrap_reg, wrap_next;
    logic                  sat_reg, sat_next;
    logic                  sticky_reg, sticky_next;
    logic                  load_err_reg, load_err_next;
    logic                  step_err_reg, step_err_next;

    logic [BCD_W-1:0]      sum_bcd;
    logic [BCD_W-1:0]      all_nines;
    logic [NUM_DIGITS-1:0] nibble_bad;
    logic                  carry_out;
    logic                  load_ok;
    logic                  step_ok;

    // Per-digit helpers: load validation, the saturation constant and the
    // ASCII view of the next count. A BCD digit 0..9 maps to ASCII simply
    // by prefixing the 0x3 high nibble.
    generate
        for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_digit
            assign nibble_bad[gi]              = (load_bcd[4*gi +: 4] > 4'd9);
            assign all_nines[4*gi +: 4]        = 4'd9;
            assign order_no_next[8*gi +: 8]    = {4'h3, count_next[4*gi +: 4]};
        end
    endgenerate

    assign load_ok = ~|nibble_bad;
    assign step_ok = (step <= 4'd9);

    // Decimal ripple add. The step enters as the carry-in of digit 0; since
    // step <= 9 and each digit <= 9, every digit sum is at most 18, so the
    // carry into higher digits is only ever 0 or 1. Kept inside one process
    // so the carry chain is a single combinational cone.
    always_comb begin
        logic [4:0] raw;
        logic [3:0] carry;
        raw     = '0;
        carry   = step;
        sum_bcd = '0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            raw = {1'b0, count_reg[4*i +: 4]} + {1'b0, carry};
            if (raw > 5'd9) begin
                sum_bcd[4*i +: 4] = 4'(raw - 5'd10);
                carry             = 4'd1;
            end else begin
                sum_bcd[4*i +: 4] = raw[3:0];
                carry             = 4'd0;
            end
        end
        carry_out = (carry != 4'd0);
    end

    // Command decode: clear > load > enable. Lower-priority commands in the
    // same cycle are dropped silently, including their error checks.
    always_comb begin
        count_next    = count_reg;
        sticky_next   = sticky_reg;
        wrap_next     = 1'b0;
        sat_next      = 1'b0;
        load_err_next = 1'b0;
        step_err_next = 1'b0;
        if (clear) begin
            count_next  = '0;
            sticky_next = 1'b0;
        end else if (load) begin
            if (load_ok) begin
                count_next  = load_bcd;
                sticky_next = 1'b0;
            end else begin
                load_err_next = 1'b1;
            end
        end else if (enable) begin
            if (!step_ok) begin
                step_err_next = 1'b1;
            end else if (carry_out) begin
                // Carry out of the top digit means the true sum exceeded
                // all nines; the digits already hold sum mod 10^N.
                sticky_next = 1'b1;
                if (SAT_MODE) begin
                    count_next = all_nines;
                    sat_next   = 1'b1;
                end else begin
                    count_next = sum_bcd;
                    wrap_next  = 1'b1;
                end
            end else begin
                count_next = sum_bcd;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count_reg    <= '0;
            order_no_reg <= {NUM_DIGITS{8'h30}};
            wrap_reg     <= 1'b0;
            sat_reg      <= 1'b0;
            sticky_reg   <= 1'b0;
            load_err_reg <= 1'b0;
            step_err_reg <= 1'b0;
        end else begin
            count_reg    <= count_next;
            order_no_reg <= order_no_next;
            wrap_reg     <= wrap_next;
            sat_reg      <= sat_next;
            sticky_reg   <= sticky_next;
            load_err_reg <= load_err_next;
            step_err_reg <= step_err_next;
        end
    end

    assign order_no   = order_no_reg;
    assign wrap       = wrap_reg;
    assign sat        = sat_reg;
    assign ovf_sticky = sticky_reg;
    assign load_err   = load_err_reg;
    assign step_err   = step_err_reg;

endmodule

// File: tb/tb_order_no_ascii_counter.sv
// tb_order_no_ascii_counter
//
// Drives a wrapping and a saturating instance of order_no_ascii_counter
// with identical stimulus. A decimal integer model predicts each cycle's
// outputs; predictions are queued when stimulus is applied and popped and
// compared after the sampling edge.
module tb_order_no_ascii_counter;

    localparam int ND   = 5;
    localparam int MAXV = 99999;

    logic            clk;
    logic            rst_n;
    logic            clear;
    logic            load;
    logic [4*ND-1:0] load_bcd;
    logic            enable;
    logic [3:0]      step;

    logic [8*ND-1:0] order_no_w, order_no_s;
    logic            wrap_w, sat_w, sticky_w, lerr_w, serr_w;
    logic            wrap_s, sat_s, sticky_s, lerr_s, serr_s;

    order_no_ascii_counter #(.NUM_DIGITS(ND), .SAT_MODE(1'b0)) dut (
        .clk(clk), .rst_n(rst_n), .clear(clear), .load(load),
        .load_bcd(load_bcd), .enable(enable), .step(step),
        .order_no(order_no_w), .wrap(wrap_w), .sat(sat_w),
        .ovf_sticky(sticky_w), .load_err(lerr_w), .step_err(serr_w)
    );

    order_no_ascii_counter #(.NUM_DIGITS(ND), .SAT_MODE(1'b1)) dut_sat (
        .clk(clk), .rst_n(rst_n), .clear(clear), .load(load),
        .load_bcd(load_bcd), .enable(enable), .step(step),
        .order_no(order_no_s), .wrap(wrap_s), .sat(sat_s),
        .ovf_sticky(sticky_s), .load_err(lerr_s), .step_err(serr_s)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // flags packed as {wrap, sat, sticky, load_err, step_err}
    typedef struct {
        logic [8*ND-1:0] ono_w;
        logic [8*ND-1:0] ono_s;
        logic [4:0]      flags_w;
        logic [4:0]      flags_s;
    } exp_t;

    exp_t exp_q[$];

    int checks = 0;
    int errors = 0;
    int cycle  = 0;

    int m_cnt[2];
    bit m_sticky[2];

    task automatic check_value(input string tag, input logic [63:0] got, input logic [63:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, want, cycle);
        end
    endtask

    function automatic logic [8*ND-1:0] to_ascii(input int v);
        logic [8*ND-1:0] r;
        int rem;
        rem = v;
        r   = '0;
        for (int k = 0; k < ND; k++) begin
            r[8*k +: 8] = 8'h30 + 8'(rem % 10);
            rem         = rem / 10;
        end
        return r;
    endfunction

    function automatic bit ascii_ok(input logic [8*ND-1:0] s);
        bit ok;
        ok = 1'b1;
        for (int k = 0; k < ND; k++)
            if (s[8*k +: 8] < 8'h30 || s[8*k +: 8] > 8'h39) ok = 1'b0;
        return ok;
    endfunction

    // Apply one cycle of stimulus, predict both instances, then compare.
    task automatic drive(input logic r, input logic c, input logic l,
                         input logic [4*ND-1:0] bcd, input logic e, input logic [3:0] s);
        exp_t  ex;
        logic  [4:0] fl[2];
        int    val, pw, sum;
        bit    valid;
        exp_t  got;

        rst_n = r; clear = c; load = l; load_bcd = bcd; enable = e; step = s;

        valid = 1'b1; val = 0; pw = 1;
        for (int k = 0; k < ND; k++) begin
            if (bcd[4*k +: 4] > 4'd9) valid = 1'b0;
            val += int'(bcd[4*k +: 4]) * pw;
            pw  *= 10;
        end

        for (int m = 0; m < 2; m++) begin
            fl[m] = 5'b0;
            if (!r) begin
                m_cnt[m] = 0; m_sticky[m] = 1'b0;
            end else if (c) begin
                m_cnt[m] = 0; m_sticky[m] = 1'b0;
            end else if (l) begin
                if (valid) begin
                    m_cnt[m] = val; m_sticky[m] = 1'b0;
                end else begin
                    fl[m][1] = 1'b1;
                end
            end else if (e) begin
                if (s > 4'd9) begin
                    fl[m][0] = 1'b1;
                end else begin
                    sum = m_cnt[m] + int'(s);
                    if (sum > MAXV) begin
                        m_sticky[m] = 1'b1;
                        if (m == 0) begin
                            m_cnt[m] = sum - (MAXV + 1); fl[m][4] = 1'b1;
                        end else begin
                            m_cnt[m] = MAXV; fl[m][3] = 1'b1;
                        end
                    end else begin
                        m_cnt[m] = sum;
                    end
                end
            end
            fl[m][2] = m_sticky[m];
        end
        ex.ono_w = to_ascii(m_cnt[0]); ex.flags_w = fl[0];
        ex.ono_s = to_ascii(m_cnt[1]); ex.flags_s = fl[1];
        exp_q.push_back(ex);

        @(posedge clk);
        @(negedge clk);
        cycle++;

        got = exp_q.pop_front();
        $display("cyc %0d rst_n=%b clr=%b ld=%b bcd=%h en=%b step=%0d -> wrap_inst \"%s\" fl=%b | sat_inst \"%s\" fl=%b",
                 cycle, r, c, l, bcd, e, s, order_no_w,
                 {wrap_w, sat_w, sticky_w, lerr_w, serr_w}, order_no_s,
                 {wrap_s, sat_s, sticky_s, lerr_s, serr_s});
        check_value("order_no_wrap", 64'(order_no_w), 64'(got.ono_w));
        check_value("flags_wrap", 64'({wrap_w, sat_w, sticky_w, lerr_w, serr_w}), 64'(got.flags_w));
        check_value("order_no_sat", 64'(order_no_s), 64'(got.ono_s));
        check_value("flags_sat", 64'({wrap_s, sat_s, sticky_s, lerr_s, serr_s}), 64'(got.flags_s));
        check_value("ascii_range_wrap", 64'(ascii_ok(order_no_w)), 64'd1);
        check_value("ascii_range_sat", 64'(ascii_ok(order_no_s)), 64'd1);
    endtask

    initial begin
        logic [4*ND-1:0] rb;
        m_cnt[0] = 0; m_cnt[1] = 0;
        m_sticky[0] = 1'b0; m_sticky[1] = 1'b0;
        rst_n = 1'b0; clear = 1'b0; load = 1'b0; load_bcd = '0; enable = 1'b0; step = '0;

        // reset
        drive(0, 0, 0, '0, 0, 4'd0);
        drive(0, 0, 0, '0, 1, 4'd3);

        // count 12 with step 1
        for (int i = 0; i < 12; i++) drive(1, 0, 0, '0, 1, 4'd1);
        // step 0 holds
        drive(1, 0, 0, '0, 1, 4'd0);

        // near top of range, step 1
        drive(1, 0, 1, 20'h99998, 0, 4'd0);
        for (int i = 0; i < 3; i++) drive(1, 0, 0, '0, 1, 4'd1);

        // near top, step 2
        drive(1, 0, 1, 20'h99997, 0, 4'd0);
        for (int i = 0; i < 2; i++) drive(1, 0, 0, '0, 1, 4'd2);
        drive(1, 0, 0, '0, 1, 4'd9);

        // carry across two digits, then rejected load
        drive(1, 0, 1, 20'h00095, 0, 4'd0);
        drive(1, 0, 0, '0, 1, 4'd7);
        drive(1, 0, 1, 20'h12A45, 0, 4'd0);

        // bad step, then all commands at once
        drive(1, 0, 0, '0, 1, 4'd12);
        drive(1, 0, 1, 20'h99999, 0, 4'd0);
        drive(1, 0, 0, '0, 1, 4'd1);
        drive(1, 1, 1, 20'h1234F, 1, 4'd15);
        // load wins over enable, bad load with enable raises no step error
        drive(1, 0, 1, 20'h00400, 1, 4'd5);
        drive(1, 0, 1, 20'hF0000, 1, 4'd14);

        // reset mid-count
        for (int i = 0; i < 3; i++) drive(1, 0, 0, '0, 1, 4'd4);
        drive(1, 0, 1, 20'h99999, 0, 4'd0);
        drive(1, 0, 0, '0, 1, 4'd1);
        drive(0, 0, 0, '0, 1, 4'd1);
        for (int i = 0; i < 3; i++) drive(1, 0, 0, '0, 1, 4'd1);

        // randomised mix
        for (int i = 0; i < 60; i++) begin
            rb = 20'($urandom);
            if ($urandom_range(0, 3) != 0)
                for (int k = 0; k < ND; k++) rb[4*k +: 4] = 4'($urandom_range(0, 9));
            if ($urandom_range(0, 4) == 0)
                rb[19:16] = 4'd9;
            drive(($urandom_range(0, 30) != 0), ($urandom_range(0, 20) == 0),
                  ($urandom_range(0, 6) == 0), rb, 1'b1,
                  4'($urandom_range(0, 11)));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/order_no_ascii_counter.md
Name: order_no_ascii_counter

Overview:
Parametrised successor to the fixed 5-digit order-number counter. Keeps an N-digit decimal (BCD) order number and presents it as ASCII characters, one byte per digit, for display and logging. Adds variable step, BCD parallel load, synchronous clear, selectable wrap or saturate at the top of range, and status flags. Sits beside the order-entry datapath and is driven by a per-order enable strobe.

Parameters:
NUM_DIGITS, 5, number of decimal digits; legal range 1..8.
SAT_MODE, 0, top-of-range policy: 0 = wrap to all zeros, 1 = saturate at all nines.

Ports:
clk  in  1  system clock, rising edge.
rst_n  in  1  synchronous active-low reset.
clear  in  1  synchronous clear of the count to zero.
load  in  1  parallel load strobe.
load_bcd  in  4*NUM_DIGITS  BCD load value; digit 0 (least significant) is in [3:0].
enable  in  1  add step to the count this cycle.
step  in  4  increment amount, legal 0..9.
order_no  out  8*NUM_DIGITS  ASCII digits; byte k = digit k; byte 0 is least significant.
wrap  out  1  one-cycle pulse: an increment wrapped past all nines (SAT_MODE=0 only).
sat  out  1  one-cycle pulse: an increment was clipped at all nines (SAT_MODE=1 only).
ovf_sticky  out  1  set on any wrap or sat event; cleared by reset, clear or an accepted load.
load_err  out  1  one-cycle pulse: load rejected because a nibble > 9.
step_err  out  1  one-cycle pulse: enable asserted with step > 9; increment suppressed.

Behaviour:
- Reset and all actions are synchronous on the rising edge of clk.
- The internal BCD register and the order_no register both update at the edge that samples the command, so latency is 1 cycle.
- Reset values: order_no = 0x30 in every byte ("000..0"). wrap, sat, ovf_sticky, load_err and step_err = 0.
- Command priority, highest first: rst_n low > clear > load > enable. Commands of lower priority in the same cycle are ignored and raise no error flag.
- clear: count = 0; ovf_sticky = 0.
- load:
  - All nibbles 0..9: count = load_bcd; ovf_sticky = 0.
  - Any nibble 10..15: count and ovf_sticky are unchanged; load_err pulses.
- enable:
  - step = 0: count holds; no flags.
  - step 1..9: count = count + step, as decimal add with ripple carry from digit 0 upward. Each digit stays 0..9.
  - step 10..15: count holds; step_err pulses.
- Top of range: the true sum is at most 10^N - 1 + 9.
  - SAT_MODE=0: result = sum mod 10^N; wrap pulses and ovf_sticky sets.
  - SAT_MODE=1: if sum > 10^N - 1, result = all nines; sat pulses and ovf_sticky sets. An increment at all nines re-pulses sat.
- A pulse is high only in the cycle after the edge that sampled its cause; otherwise 0.
- Every byte of order_no is 0x30 + digit. No other byte values are ever produced.
- rst_n low mid-count returns everything to reset values on the next edge, with no residual flags.
- The count must always be valid BCD. The verification engineer checks this on every cycle.

Test Plan:
1. Reset, then enable=1 with step=1 for 12 cycles -> order_no "00012"; all flags 0 throughout.
2. SAT_MODE=0: load 0x99998, then 3 cycles of enable with step=1 -> "99999", "00000" with wrap=1 in that cycle only, then "00001"; ovf_sticky=1 from the wrap onward.
3. SAT_MODE=1: load 0x99997, then 2 cycles of enable with step=2 -> "99999" (sat=0), then "99999" with sat=1 and ovf_sticky=1.
4. Load 0x00095, then enable with step=7 -> "00102" (carry across two digits). Then load 0x12A45 -> load_err=1, order_no stays "00102".
5. Enable with step=12 -> step_err=1, count unchanged. Assert clear, load and enable in the same cycle -> "00000", ovf_sticky=0, load_err=0.
6. rst_n low for one cycle during continuous enable -> "00000" and all flags 0 on the next edge; counting resumes from "00001" once rst_n is high again.
